// File: rtl/gupta_pkg.sv
// Shared types, LFSR constants and the Gupta bit-select rule
// for the stochastic stream generator.
package gupta_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } gupta_state_e;

  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Select p[k] where k is the most significant set bit of r.
  function automatic logic gupta_bit(
    input logic [15:0] r,
    input logic [15:0] p
  );
    logic b;
    b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (r[k]) b = p[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gupta_enc.sv
// Single-channel combinational Gupta encoder:
// random slice + probability word -> one stream bit.
module gupta_enc
  import gupta_pkg::*;
#(
  parameter int M = 8
) (
  input  logic [M-1:0] rnd,
  input  logic [M-1:0] p,
  output logic         q
);

  assign q = gupta_bit(16'(rnd), 16'(p));

endmodule

// File: rtl/gupta_stream_gen.sv
// Multi-channel stochastic stream generator with product output.
// Define GUPTA_ONES_CNT_EN to enable the ones_o product counter.
module gupta_stream_gen
  import gupta_pkg::*;
#(
  parameter int          M     = 8,
  parameter int          N_CH  = 4,
  parameter int          LEN_W = 10,
  parameter logic [31:0] SEED  = 32'hACE1_2468
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [N_CH*M-1:0] proba_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              seed_ld_i,
  input  logic [31:0]       seed_i,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [N_CH-1:0]   bits_o,
  output logic              prod_o,
  output logic              done_o,
  output logic [LEN_W:0]    ones_o
);

  localparam int W = N_CH * M;

  if (W > LFSR_W) begin : g_bad_width
    $error("gupta_stream_gen: N_CH*M must not exceed 32");
  end
  if (SEED == 32'd0) begin : g_bad_seed
    $error("gupta_stream_gen: SEED must be nonzero");
  end

  gupta_state_e state;
  gupta_state_e nxt;

  logic [31:0]      lfsr;
  logic [31:0]      lfsr_nxt;
  logic [W-1:0]     proba_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [N_CH-1:0]  enc;
  logic             accept;
  logic             last;
  logic             run;

  assign run    = (state == RUN);
  assign accept = run & ready_i;
  assign last   = (cnt == len_q - 1'b1);

  assign lfsr_nxt = {1'b0, lfsr[31:1]}
                  ^ (lfsr[0] ? LFSR_POLY : 32'd0);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    gupta_enc #(.M(M)) u_enc (
      .rnd (lfsr[c*M +: M]),
      .p   (proba_q[c*M +: M]),
      .q   (enc[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start_i) nxt = (len_i != '0) ? RUN : DONE;
      end
      RUN: begin
        if (accept && last) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_o = run;
    busy_o  = (state != IDLE);
    done_o  = (state == DONE);
    bits_o  = run ? enc : '0;
    prod_o  = run & (&enc);
  end

  // Seed load precedes start so the first beat sees the new seed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr    <= SEED;
      proba_q <= '0;
      len_q   <= '0;
      cnt     <= '0;
    end else if (state == IDLE) begin
      if (seed_ld_i)
        lfsr <= (seed_i == 32'd0) ? SEED : seed_i;
      if (start_i) begin
        proba_q <= proba_i;
        len_q   <= len_i;
        cnt     <= '0;
      end
    end else if (accept) begin
      lfsr <= lfsr_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

`ifdef GUPTA_ONES_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)
      ones_o <= '0;
    else if (state == IDLE && start_i)
      ones_o <= '0;
    else if (accept && prod_o)
      ones_o <= ones_o + 1'b1;
  end
`else
  assign ones_o = '0;
`endif

endmodule

// File: tb/tb_gupta_stream_gen.sv
// Randomized bench for gupta_stream_gen against a
// behavioural stream model.
module tb_gupta_stream_gen;

  localparam int          M     = 8;
  localparam int          N_CH  = 4;
  localparam int          LEN_W = 10;
  localparam logic [31:0] SEED  = 32'hACE1_2468;

  logic              clk_i = 0;
  logic              rst_i = 1;
  logic              start_i = 0;
  logic [N_CH*M-1:0] proba_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              seed_ld_i = 0;
  logic [31:0]       seed_i = '0;
  logic              ready_i = 0;
  logic              busy_o;
  logic              valid_o;
  logic [N_CH-1:0]   bits_o;
  logic              prod_o;
  logic              done_o;
  logic [LEN_W:0]    ones_o;

  gupta_stream_gen #(
    .M(M), .N_CH(N_CH), .LEN_W(LEN_W), .SEED(SEED)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .proba_i   (proba_i),
    .len_i     (len_i),
    .seed_ld_i (seed_ld_i),
    .seed_i    (seed_i),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .bits_o    (bits_o),
    .prod_o    (prod_o),
    .done_o    (done_o),
    .ones_o    (ones_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  longint m_lfsr;
  int     m_ones;
  logic [N_CH-1:0] seq[$];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic longint lfsr_adv(input longint s);
    longint t;
    t = s / 2;
    if (s % 2 == 1) t = t ^ 64'h8020_0003;
    return t;
  endfunction

  // Highest set bit of the random slice picks the probability bit.
  function automatic int ch_bit(input int r, input int p);
    int k;
    if (r == 0) return 0;
    k = $clog2(r + 1) - 1;
    return (p >> k) & 1;
  endfunction

  function automatic int exp_bits(input longint s,
                                  input longint pr);
    int b;
    b = 0;
    for (int c = 0; c < N_CH; c++) begin
      int r, p;
      r = int'((s >> (c * M)) % 256);
      p = int'((pr >> (c * M)) % 256);
      b = b + (ch_bit(r, p) << c);
    end
    return b;
  endfunction

  function automatic int exp_ones();
`ifdef GUPTA_ONES_CNT_EN
    return m_ones;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    rst_i = 1;
    start_i = 0;
    seed_ld_i = 0;
    ready_i = 0;
    step();
    step();
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_bits", bits_o, 0);
    check("rst_prod", prod_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ones", ones_o, 0);
    rst_i = 0;
    m_lfsr = SEED;
    m_ones = 0;
  endtask

  // rdy_pct: chance of ready per cycle; poke_at: beat at which a
  // stray start is issued; rst_at: beat at which reset is asserted.
  task automatic run(input longint pr, input int len,
                     input int rdy_pct, input int poke_at,
                     input int rst_at, input bit record);
    int beats, cyc, b;
    bit poked;
    poked = 0;
    proba_i = pr[N_CH*M-1:0];
    len_i = len[LEN_W-1:0];
    start_i = 1;
    step();
    start_i = 0;
    seed_ld_i = 0;
    m_ones = 0;
    if (record) seq.delete();
    if (len == 0) begin
      check("z_done", done_o, 1);
      check("z_valid", valid_o, 0);
      check("z_busy", busy_o, 1);
      step();
      check("z_done2", done_o, 0);
      check("z_valid2", valid_o, 0);
      check("z_busy2", busy_o, 0);
      check("z_ones", ones_o, exp_ones());
      return;
    end
    beats = 0;
    cyc = 0;
    while (beats < len && cyc < len * 20 + 50) begin
      if (beats == rst_at) begin
        rst_i = 1;
        step();
        check("mr_busy", busy_o, 0);
        check("mr_valid", valid_o, 0);
        check("mr_bits", bits_o, 0);
        check("mr_prod", prod_o, 0);
        check("mr_done", done_o, 0);
        check("mr_ones", ones_o, 0);
        rst_i = 0;
        m_lfsr = SEED;
        m_ones = 0;
        return;
      end
      start_i = 0;
      if (beats == poke_at && !poked) begin
        start_i = 1;
        proba_i = ~proba_i;
        len_i = 3;
        seed_ld_i = 1;
        seed_i = 32'h1234_5678;
        poked = 1;
      end
      ready_i = ($urandom_range(99) < rdy_pct);
      b = exp_bits(m_lfsr, pr);
      check("valid", valid_o, 1);
      check("busy", busy_o, 1);
      check("done_run", done_o, 0);
      check("bits", bits_o, b);
      check("prod", prod_o, (b == (1 << N_CH) - 1));
      check("ones_run", ones_o, exp_ones());
      if (ready_i) begin
        if (b == (1 << N_CH) - 1) m_ones++;
        if (record) seq.push_back(b[N_CH-1:0]);
        m_lfsr = lfsr_adv(m_lfsr);
        beats++;
      end
      step();
      start_i = 0;
      seed_ld_i = 0;
      cyc++;
    end
    ready_i = 0;
    check("beats", beats, len);
    check("end_done", done_o, 1);
    check("end_valid", valid_o, 0);
    step();
    check("end_done2", done_o, 0);
    check("end_busy", busy_o, 0);
    check("end_ones", ones_o, exp_ones());
  endtask

  logic [N_CH-1:0] ref_seq[$];
  int first_b;

  initial begin
    do_reset();

    // zero-length stream
    run(64'h1122_3344, 0, 100, -1, -1, 0);

    // all-zero probabilities
    run(64'h0, 16, 100, -1, -1, 0);

    // MSB-only words, long stream
    run(64'h8080_8080, 1023, 100, -1, -1, 0);
`ifdef GUPTA_ONES_CNT_EN
    check("ones_range", (m_ones > 20 && m_ones < 140), 1);
`endif

    // stall insensitivity
    do_reset();
    run(64'hC3A5_F00F, 32, 100, -1, -1, 1);
    ref_seq = seq;
    do_reset();
    run(64'hC3A5_F00F, 32, 40, -1, -1, 1);
    check("seq_len", seq.size(), ref_seq.size());
    for (int i = 0; i < 32 && i < seq.size(); i++)
      check("seq_eq", seq[i], ref_seq[i]);

    // mid-run reset, then restart from beat 0
    run(64'hFFFF_FFFF, 20, 100, -1, 5, 0);
    run(64'hFFFF_FFFF, 20, 100, -1, -1, 1);
    first_b = exp_bits(SEED, 64'hFFFF_FFFF);
    check("restart_b0", seq[0], first_b);

    // stray start/seed during RUN, then seed 0 reload
    run(64'h5A5A_5A5A, 8, 100, 3, -1, 0);
    seed_ld_i = 1;
    seed_i = 32'h0;
    step();
    seed_ld_i = 0;
    m_lfsr = SEED;
    run(64'h7E7E_7E7E, 12, 100, -1, -1, 1);
    first_b = exp_bits(SEED, 64'h7E7E_7E7E);
    check("reseed_b0", seq[0], first_b);

    // seed load together with start
    seed_ld_i = 1;
    seed_i = 32'hDEAD_BEEF;
    m_lfsr = 32'hDEAD_BEEF;
    run(64'hF1E2_D3C4, 40, 70, -1, -1, 0);

    for (int t = 0; t < 6; t++) begin
      longint pr;
      pr = {$urandom(), $urandom()};
      run(pr, int'($urandom_range(1, 60)), 60, -1, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
